// File: rtl/seq_detect_pkg.sv
// Shared types, sizes and helpers for the programmable serial sequence detector.
package seq_detect_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_TO_W  = 16;
    localparam int LEN_W     = $clog2(DEF_PAT_W + 1);
    localparam int MASK_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Keep only the low 'len' bits of a pattern; bit 0 is the most recent bit.
    function automatic logic [MASK_W-1:0] mask_pat(input logic [MASK_W-1:0] pat,
                                                   input int unsigned       len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return pat & m;
    endfunction

endpackage

// File: rtl/seq_detect_if.sv
// Configuration channel of the sequence detector.
// Handshake: a config word transfers on a rising clock edge where cfg_valid && cfg_ready;
// the master holds all cfg_* fields stable while cfg_valid is high and not yet accepted.
interface seq_detect_if
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TO_W  = DEF_TO_W,
    parameter int LW    = $clog2(PAT_W + 1)
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LW-1:0]    cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic [TO_W-1:0]  cfg_timeout;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        output cfg_ready
    );

endinterface

// File: rtl/seq_detect_ctrl_shift_cmp.sv
// History shift register plus length-masked compare; 'hit' reflects the history
// as it will be after the bit currently offered on 'a' is shifted in.
module seq_shift_cmp
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LW    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             a,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LW-1:0]    len,
    output logic             hit
);

    logic [PAT_W-1:0]  hist_q, hist_d, new_hist;
    logic [LW-1:0]     hcnt_q, hcnt_d, new_hcnt;
    logic [MASK_W-1:0] hist_m, pat_m;

    always_comb begin
        new_hist = {hist_q[PAT_W-2:0], a};
        new_hcnt = (hcnt_q == LW'(PAT_W)) ? hcnt_q : hcnt_q + 1'b1;
        hist_m   = mask_pat(MASK_W'(new_hist), 32'(len));
        pat_m    = mask_pat(MASK_W'(pattern), 32'(len));
        hit      = shift_en && (hist_m == pat_m) && (new_hcnt >= len);

        hist_d = hist_q;
        hcnt_d = hcnt_q;
        if (clear) begin
            hist_d = '0;
            hcnt_d = '0;
        end else if (shift_en) begin
            hist_d = new_hist;
            // Without overlap the next match must be built from fresh bits only.
            hcnt_d = (hit && !overlap) ? '0 : new_hcnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            hcnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            hcnt_q <= hcnt_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequenced, configurable serial pattern detector: config -> arm -> run -> done,
// counting matches and ending on target, timeout or abort.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TO_W  = DEF_TO_W
) (
    input  logic             clk,
    input  logic             reset_n,
    seq_detect_if.slave      cfg_if,
    input  logic             start,
    input  logic             abort,
    input  logic             clr,
    input  logic             a,
    input  logic             a_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             timeout_flag,
    output logic             cfg_err,
    output state_t           dbg_state
);

    localparam int LW = $clog2(PAT_W + 1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             err_q, err_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic             tf_q, tf_d;
    logic             run_clear, hit, tgt_hit, to_hit, len_bad;

    seq_shift_cmp #(.PAT_W(PAT_W), .LW(LW)) u_shift_cmp (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (run_clear),
        .shift_en ((state_q == RUN) && a_valid),
        .a        (a),
        .overlap  (ovl_q),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        tgt_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);
        to_hit  = (to_q != '0) && (timer_q == to_q - 1'b1);
        len_bad = (cfg_if.cfg_len == '0) || (cfg_if.cfg_len > LW'(PAT_W));

        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        tgt_d     = tgt_q;
        to_d      = to_q;
        err_d     = err_q;
        match_d   = 1'b0;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        tf_d      = tf_q;
        run_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_if.cfg_valid) begin
                    pat_d = cfg_if.cfg_pattern;
                    len_d = cfg_if.cfg_len;
                    ovl_d = cfg_if.cfg_overlap;
                    tgt_d = cfg_if.cfg_target;
                    to_d  = cfg_if.cfg_timeout;
                    err_d = len_bad;
                    if (!len_bad) state_d = ARMED;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d   = RUN;
                    run_clear = 1'b1;
                end
            end
            RUN: begin
                // Abort drops any match found this cycle and leaves the count untouched.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                    end
                    if (tgt_hit) begin
                        state_d = DONE;
                    end else if (to_hit) begin
                        state_d = DONE;
                        tf_d    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d   = RUN;
                    run_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (run_clear) begin
            cnt_d   = '0;
            timer_d = '0;
            tf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            timer_q <= '0;
            tf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            to_q    <= to_d;
            err_q   <= err_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            tf_q    <= tf_d;
        end
    end

    assign cfg_if.cfg_ready = (state_q == IDLE);
    assign match            = match_q;
    assign match_count      = cnt_q;
    assign busy             = (state_q == RUN);
    assign done             = (state_q == DONE);
    assign timeout_flag     = tf_q;
    assign cfg_err          = err_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: queue-based reference model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  localparam int PW = 8;
  localparam int CW = 8;
  localparam int TW = 16;
  localparam int LW = $clog2(PW + 1);
  localparam int CNT_MAX = (1 << CW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic start, abort, clr, a, a_valid;
  logic match, busy, done, timeout_flag, cfg_err;
  logic [CW-1:0] match_count;
  state_t dbg_state;

  seq_detect_if #(.PAT_W(PW), .CNT_W(CW), .TO_W(TW)) cfg_if ();

  seq_detect_ctrl #(.PAT_W(PW), .CNT_W(CW), .TO_W(TW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_if       (cfg_if),
    .start        (start),
    .abort        (abort),
    .clr          (clr),
    .a            (a),
    .a_valid      (a_valid),
    .match        (match),
    .match_count  (match_count),
    .busy         (busy),
    .done         (done),
    .timeout_flag (timeout_flag),
    .cfg_err      (cfg_err),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: 0=idle 1=armed 2=run 3=done
  int ms = 0;
  logic [PW-1:0] m_pat = '0;
  int m_len = 0;
  bit m_ovl = 0;
  int m_tgt = 0;
  int m_to = 0;
  bit m_err = 0;
  bit m_match = 0;
  bit m_tf = 0;
  int m_cnt = 0;
  int m_cyc = 0;
  bit m_q[$];

  task automatic m_enter_run();
    ms = 2;
    m_cnt = 0;
    m_cyc = 0;
    m_tf = 0;
    m_q.delete();
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_tgt = 0; m_to = 0;
      m_err = 0; m_match = 0; m_tf = 0; m_cnt = 0; m_cyc = 0;
      m_q.delete();
    end else begin
      bit hit;
      bit tgt;
      m_match = 0;
      case (ms)
        0: if (cfg_if.cfg_valid) begin
          m_pat = cfg_if.cfg_pattern;
          m_len = int'(cfg_if.cfg_len);
          m_ovl = cfg_if.cfg_overlap;
          m_tgt = int'(cfg_if.cfg_target);
          m_to = int'(cfg_if.cfg_timeout);
          if (m_len == 0 || m_len > PW) m_err = 1;
          else begin m_err = 0; ms = 1; end
        end
        1: if (abort) ms = 0; else if (start) m_enter_run();
        2: if (abort) ms = 0;
        else begin
          hit = 0;
          m_cyc++;
          if (a_valid) begin
            m_q.push_back(a);
            if (m_q.size() > PW) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
              hit = 1;
              for (int i = 0; i < m_len; i++)
                if (m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 0;
            end
          end
          if (hit) begin
            m_match = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (!m_ovl) m_q.delete();
          end
          tgt = hit && (m_tgt != 0) && (m_cnt == m_tgt);
          if (tgt) ms = 3;
          else if (m_to != 0 && m_cyc == m_to) begin ms = 3; m_tf = 1; end
        end
        3: if (clr) ms = 0; else if (start) m_enter_run();
        default: ms = 0;
      endcase
    end
  end

  // scoreboard compare: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(ms == 0));
    chk("match", 32'(match), 32'(m_match));
    chk("match_count", 32'(match_count), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(ms == 2));
    chk("done", 32'(done), 32'(ms == 3));
    chk("timeout_flag", 32'(timeout_flag), 32'(m_tf));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("dbg_state_run", 32'(dbg_state == RUN), 32'(ms == 2));
  end

  int pulses = 0;
  always @(negedge clk) if (match) pulses++;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_cfg(input logic [PW-1:0] pat, input int len, input bit ovl,
                        input int tgt, input int to);
    cfg_if.cfg_pattern = pat;
    cfg_if.cfg_len = LW'(len);
    cfg_if.cfg_overlap = ovl;
    cfg_if.cfg_target = CW'(tgt);
    cfg_if.cfg_timeout = TW'(to);
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  // bits[n-1] is sent first
  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      a = bits[i];
      a_valid = 1'b1;
      tick();
    end
    a_valid = 1'b0;
    a = 1'b0;
  endtask

  int p0;

  initial begin
    start = 0; abort = 0; clr = 0; a = 0; a_valid = 0;
    cfg_if.cfg_valid = 0; cfg_if.cfg_pattern = '0; cfg_if.cfg_len = '0;
    cfg_if.cfg_overlap = 0; cfg_if.cfg_target = '0; cfg_if.cfg_timeout = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(match_count), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);

    // overlapping 1011 over 1,0,1,1,0,1,1
    do_cfg(8'b1011, 4, 1, 0, 0);
    chk("t1_armed_ready", 32'(cfg_if.cfg_ready), 0);
    do_start();
    p0 = pulses;
    send_bits(16'b1011011, 7);
    tick();
    chk("t1_pulses", 32'(pulses - p0), 2);
    chk("t1_count", 32'(match_count), 2);
    chk("t1_busy", 32'(busy), 1);
    do_abort();
    chk("t1_abort_idle", 32'(cfg_if.cfg_ready), 1);
    chk("t1_count_held", 32'(match_count), 2);

    // same stream without overlap
    do_cfg(8'b1011, 4, 0, 0, 0);
    do_start();
    p0 = pulses;
    send_bits(16'b1011011, 7);
    tick();
    chk("t2_pulses", 32'(pulses - p0), 1);
    chk("t2_count", 32'(match_count), 1);
    do_abort();

    // target 2 with 111
    do_cfg(8'b111, 3, 1, 2, 0);
    do_start();
    p0 = pulses;
    send_bits(16'b1111, 4);
    chk("t3_done_at_2nd", 32'(done), 1);
    chk("t3_last_pulse", 32'(match), 1);
    send_bits(16'b1, 1);
    tick();
    chk("t3_count", 32'(match_count), 2);
    chk("t3_pulses", 32'(pulses - p0), 2);
    do_clr();
    chk("t3_clr_ready", 32'(cfg_if.cfg_ready), 1);
    chk("t3_clr_done", 32'(done), 0);

    // timeout 10, pattern absent
    do_cfg(8'h01, 1, 1, 0, 10);
    do_start();
    for (int i = 0; i < 9; i++) begin
      a = 1'b0;
      a_valid = (i % 2 == 0);
      tick();
    end
    a_valid = 1'b0;
    chk("t4_busy_9", 32'(busy), 1);
    chk("t4_done_9", 32'(done), 0);
    tick();
    chk("t4_done_10", 32'(done), 1);
    chk("t4_tflag", 32'(timeout_flag), 1);
    chk("t4_count", 32'(match_count), 0);
    do_start();
    chk("t4_restart_busy", 32'(busy), 1);
    chk("t4_restart_tflag", 32'(timeout_flag), 0);
    do_abort();

    // target and timeout on the same cycle
    do_cfg(8'h01, 1, 1, 3, 3);
    do_start();
    send_bits(16'b111, 3);
    chk("t4b_done", 32'(done), 1);
    chk("t4b_tflag", 32'(timeout_flag), 0);
    chk("t4b_count", 32'(match_count), 3);
    do_clr();

    // abort together with a completing bit
    do_cfg(8'b1011, 4, 1, 0, 0);
    do_start();
    p0 = pulses;
    send_bits(16'b101101, 6);
    a = 1'b1; a_valid = 1'b1; abort = 1'b1;
    tick();
    a = 1'b0; a_valid = 1'b0; abort = 1'b0;
    chk("t5_idle", 32'(cfg_if.cfg_ready), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    tick();
    chk("t5_pulses", 32'(pulses - p0), 1);
    chk("t5_count", 32'(match_count), 1);

    // reset mid-run
    do_cfg(8'b1011, 4, 1, 0, 0);
    do_start();
    send_bits(16'b10, 2);
    reset_n = 1'b0;
    #1;
    chk("t5r_ready", 32'(cfg_if.cfg_ready), 1);
    chk("t5r_busy", 32'(busy), 0);
    chk("t5r_count", 32'(match_count), 0);
    chk("t5r_match", 32'(match), 0);
    tick();
    reset_n = 1'b1;
    tick();
    do_start();
    chk("t5r_cfg_lost", 32'(busy), 0);

    // illegal lengths
    do_cfg(8'b1011, 0, 1, 0, 0);
    chk("t6_len0_err", 32'(cfg_err), 1);
    chk("t6_len0_idle", 32'(cfg_if.cfg_ready), 1);
    do_start();
    chk("t6_start_ignored", 32'(busy), 0);
    do_cfg(8'b1011, 9, 1, 0, 0);
    chk("t6_len9_err", 32'(cfg_err), 1);
    chk("t6_len9_idle", 32'(cfg_if.cfg_ready), 1);
    do_cfg(8'b1011, 4, 1, 0, 0);
    chk("t6_len4_err", 32'(cfg_err), 0);
    chk("t6_len4_armed", 32'(cfg_if.cfg_ready), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial sequence-detector controller. It loads a pattern (1..PAT_W bits), an overlap mode, a match target and a timeout, then runs detection on a serial bit stream (a/a_valid). It counts matches and ends the run on target reached, timeout or abort. It generalises the fixed Moore detector into a configurable, sequenced unit.

Parameters:
PAT_W, 8, maximum pattern length in bits
CNT_W, 8, width of match target/counter
TO_W, 16, width of timeout cycle counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config offered
cfg_ready  out  1  config accepted when cfg_valid&&cfg_ready
cfg_pattern  in  PAT_W  pattern; bit 0 = most recent bit
cfg_len  in  $clog2(PAT_W+1)  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_target  in  CNT_W  matches to finish; 0 = no count limit
cfg_timeout  in  TO_W  RUN-cycle limit; 0 = disabled
start  in  1  begin run
abort  in  1  cancel run
clr  in  1  leave DONE
a  in  1  serial data bit
a_valid  in  1  a is sampled this cycle
match  out  1  1-cycle pulse per detected match
match_count  out  CNT_W  matches in current/last run
busy  out  1  state==RUN
done  out  1  state==DONE
timeout_flag  out  1  last run ended by timeout
cfg_err  out  1  last config had illegal length

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 except cfg_ready=1; config registers, history, counters and timer cleared.
- States: IDLE, ARMED, RUN, DONE. All outputs are registered (Moore).
- IDLE: cfg_ready=1. On handshake, config is latched.
  - If cfg_len==0 or cfg_len>PAT_W: cfg_err<=1, stay IDLE.
  - Otherwise: cfg_err<=0, go to ARMED.
  - start is ignored in IDLE.
- ARMED: cfg_ready=0. start -> RUN; entry clears match_count, timer, history count and timeout_flag.
- RUN, per accepted bit (a_valid=1):
  - hist <= {hist[PAT_W-2:0], a}; hcnt increments, saturating at PAT_W.
  - Match condition: the low cfg_len bits of the new hist equal the low cfg_len bits of cfg_pattern, and new hcnt >= cfg_len.
  - On match: match pulses high the cycle after the sampling edge (latency 1); match_count increments.
  - If cfg_overlap=0, hcnt resets to 0 on a match, so the next match needs cfg_len fresh bits.
- RUN, timer: increments every RUN cycle, including cycles with a_valid=0. When timer == cfg_timeout-1 and cfg_timeout != 0: go to DONE with timeout_flag=1.
- RUN, target: the match that makes match_count == cfg_target (target != 0) sends the FSM to DONE. That final match pulse is still emitted.
- With cfg_target=0, match_count saturates at all-ones.
- Simultaneous events:
  - abort has top priority in ARMED and RUN: go to IDLE, no done, match_count held, any pending match pulse suppressed.
  - Target reached and timeout in the same cycle: DONE with timeout_flag=0.
  - start in RUN is ignored.
- DONE: done=1 held.
  - start -> RUN with the same config (counters cleared).
  - clr -> IDLE.
  - start and clr together -> clr wins.
  - match_count and timeout_flag stay visible until the next RUN entry.
- a_valid outside RUN is ignored; history is not updated.
- Reset mid-run: immediate return to the reset state; the configuration is lost.

Decomposition:
- Package seq_detect_pkg holds:
  - state_t enum {IDLE, ARMED, RUN, DONE};
  - localparam LEN_W = $clog2(PAT_W+1);
  - a function masking a pattern to a given length.
- One sub-module, seq_shift_cmp: shift register, history counter and masked compare. It outputs a combinational hit; seq_detect_ctrl registers it into match.
- FSM, counters and timer live in seq_detect_ctrl.

Test Plan:
- Pattern 4'b1011, len 4, overlap=1, target 0, timeout 0; bits 1,0,1,1,0,1,1 back-to-back -> match pulses after bits 4 and 7, match_count=2, busy stays 1.
- Same stream with overlap=0 -> single match after bit 4, match_count=1.
- Pattern 3'b111, len 3, target 2, overlap=1; stream of five 1s -> matches after bits 3 and 4, done=1 the cycle after the 2nd match, further bits ignored, match_count=2. Then clr -> IDLE with cfg_ready=1.
- Timeout 10, pattern never present (all zeros, a_valid toggling) -> DONE exactly 10 cycles after RUN entry, timeout_flag=1, match_count=0. Then start -> RUN with timeout_flag cleared.
- Abort in the same cycle as a completing bit -> no match pulse, state IDLE, done=0. Separately, reset_n low mid-RUN -> all outputs at reset values, cfg_ready=1.
- Config with cfg_len=0, then cfg_len=9 -> cfg_err=1, stays IDLE. Then cfg_len=4 -> cfg_err=0, ARMED (cfg_ready=0).
